bfm_ahbl_master: RTL and testbench

BFM_AHBL_MASTER -- requirements
Module: bfm_ahbl_master

---
 rtl/bfm_ahbl_master_if.sv | 44 ++++
 rtl/bfm_ahbl_master.sv | 221 ++++++++++++++++++++++
 tb/tb_bfm_ahbl_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfm_ahbl_master_if.sv
// Command, write/read data streams, AHB-Lite bus and status for the AHB-Lite master BFM.
interface bfm_ahbl_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [2:0]            CMD_SIZE;
  logic [8:0]            CMD_LEN;
  logic                  WD_VALID;
  logic                  WD_READY;
  logic [DATA_WIDTH-1:0] WD_DATA;
  logic                  RD_VALID;
  logic                  RD_LAST;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic                  DONE;
  logic                  ERROR;
  logic                  TIMEOUT_ERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_LEN, WD_VALID, WD_DATA,
           HRDATA, HREADY, HRESP,
    output CMD_READY, WD_READY, RD_VALID, RD_LAST, RD_DATA,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, DONE, ERROR, TIMEOUT_ERR
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_LEN, WD_VALID, WD_DATA,
           HRDATA, HREADY, HRESP,
    input  CMD_READY, WD_READY, RD_VALID, RD_LAST, RD_DATA,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, DONE, ERROR, TIMEOUT_ERR
  );
endinterface

// File: rtl/bfm_ahbl_master.sv
// AHB-Lite master BFM: turns one command (addr/size/len) into a SINGLE or INCR burst
// with pipelined address/data phases, write-data flow control, error abort and timeout.
module bfm_ahbl_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic               SYSCLK,
  input  logic               SYSRST,
  bfm_ahbl_master_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ABORT} state_t;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));
  localparam int         TW       = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-1);

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_haddr, w_haddr_nxt, r_naddr, w_naddr_nxt;
  logic [1:0]            r_htrans, w_htrans_nxt;
  logic                  r_hwrite, w_hwrite_nxt;
  logic [2:0]            r_hsize, w_hsize_nxt, r_hburst, w_hburst_nxt;
  logic [DATA_WIDTH-1:0] r_hwdata, w_hwdata_nxt, r_wbuf, w_wbuf_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [8:0]            r_len, w_len_nxt, r_issue_left, w_issue_left_nxt;
  logic [8:0]            r_data_left, w_data_left_nxt;
  logic                  r_dphase, w_dphase_nxt;
  logic [TW-1:0]         r_to_cnt, w_to_cnt_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt, r_rd_last, w_rd_last_nxt;
  logic                  r_done, w_done_nxt, r_error, w_error_nxt, r_to_err, w_to_err_nxt;

  logic w_cmd_ready, w_accept, w_cmd_ok, w_active, w_xfer, w_adv, w_stall;
  logic w_timeout, w_err, w_data_done, w_last_done, w_first, w_issue;

  assign w_cmd_ready = (r_state == S_IDLE) & ~SYSRST;
  assign w_accept    = bus.CMD_VALID & w_cmd_ready;
  assign w_cmd_ok    = (bus.CMD_LEN != 9'd0) & (bus.CMD_LEN <= 9'(MAX_BURST)) &
                       (bus.CMD_SIZE <= MAX_SIZE);
  assign w_active    = (r_state == S_ADDR) | (r_state == S_BURST) | (r_state == S_DRAIN);
  assign w_xfer      = r_htrans[1];
  // Address-phase signals may only move when no stalled transfer is pending on the bus.
  assign w_adv       = bus.HREADY | (~w_xfer & ~r_dphase);
  assign w_stall     = r_dphase & ~bus.HREADY;
  assign w_timeout   = w_stall & (r_to_cnt == TO_LAST);
  assign w_err       = w_active & r_dphase & bus.HRESP & ~bus.HREADY;
  assign w_data_done = w_active & r_dphase & bus.HREADY;
  assign w_last_done = w_data_done & (r_data_left == 9'd1);
  assign w_first     = (r_issue_left == r_len);
  assign w_issue     = (w_accept & w_cmd_ok & (~bus.CMD_WRITE | bus.WD_VALID)) |
                       (w_active & w_adv & (r_issue_left != 9'd0) & (~r_hwrite | bus.WD_VALID));

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_cmd_ok) w_state_nxt = S_ADDR;
      S_ADDR, S_BURST, S_DRAIN: begin
        if (w_err)                          w_state_nxt = S_ABORT;
        else if (w_timeout || w_last_done)  w_state_nxt = S_IDLE;
        else if (w_adv && r_state != S_DRAIN) begin
          if (w_issue)                      w_state_nxt = w_first ? S_ADDR : S_BURST;
          else if (r_issue_left == 9'd0)    w_state_nxt = S_DRAIN;
          else if (!w_first)                w_state_nxt = S_BURST;
        end
      end
      S_ABORT: if (bus.HREADY || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_haddr_nxt      = r_haddr;
    w_htrans_nxt     = r_htrans;
    w_hwrite_nxt     = r_hwrite;
    w_hsize_nxt      = r_hsize;
    w_hburst_nxt     = r_hburst;
    w_hwdata_nxt     = r_hwdata;
    w_wbuf_nxt       = r_wbuf;
    w_naddr_nxt      = r_naddr;
    w_len_nxt        = r_len;
    w_issue_left_nxt = r_issue_left;
    w_data_left_nxt  = r_data_left;
    w_dphase_nxt     = r_dphase;
    w_to_cnt_nxt     = w_stall ? r_to_cnt + TW'(1) : '0;
    w_rd_valid_nxt   = 1'b0;
    w_rd_last_nxt    = 1'b0;
    w_rd_data_nxt    = r_rd_data;
    w_done_nxt       = 1'b0;
    w_error_nxt      = r_error;
    w_to_err_nxt     = r_to_err;
    if (w_accept) begin
      // A rejected command never touches the bus; it just reports and completes.
      w_error_nxt  = ~w_cmd_ok;
      w_to_err_nxt = 1'b0;
      w_done_nxt   = ~w_cmd_ok;
      if (w_cmd_ok) begin
        w_hwrite_nxt     = bus.CMD_WRITE;
        w_hsize_nxt      = bus.CMD_SIZE;
        w_hburst_nxt     = (bus.CMD_LEN == 9'd1) ? B_SINGLE : B_INCR;
        w_len_nxt        = bus.CMD_LEN;
        w_data_left_nxt  = bus.CMD_LEN;
        w_issue_left_nxt = bus.CMD_LEN;
        w_naddr_nxt      = bus.CMD_ADDR;
        if (w_issue) begin
          w_haddr_nxt      = bus.CMD_ADDR;
          w_htrans_nxt     = T_NSEQ;
          w_wbuf_nxt       = bus.WD_DATA;
          w_naddr_nxt      = bus.CMD_ADDR + (ADDR_WIDTH'(1) << bus.CMD_SIZE);
          w_issue_left_nxt = bus.CMD_LEN - 9'd1;
        end
      end
    end else if (w_err) begin
      w_htrans_nxt     = T_IDLE;
      w_error_nxt      = 1'b1;
      w_issue_left_nxt = 9'd0;
    end else if (w_timeout) begin
      w_htrans_nxt     = T_IDLE;
      w_to_err_nxt     = 1'b1;
      w_done_nxt       = 1'b1;
      w_dphase_nxt     = 1'b0;
      w_issue_left_nxt = 9'd0;
      w_to_cnt_nxt     = '0;
    end else if (r_state == S_ABORT) begin
      if (bus.HREADY) begin
        w_done_nxt   = 1'b1;
        w_dphase_nxt = 1'b0;
      end
    end else if (w_active) begin
      if (w_data_done) begin
        w_data_left_nxt = r_data_left - 9'd1;
        w_done_nxt      = w_last_done;
        if (!r_hwrite) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = (r_data_left == 9'd1);
          w_rd_data_nxt  = bus.HRDATA;
        end
      end
      if (w_adv) begin
        w_dphase_nxt = w_xfer;
        if (w_xfer && r_hwrite) w_hwdata_nxt = r_wbuf;
        if (w_issue) begin
          // A beat starting a new 1 KB page must restart the burst as NONSEQ.
          w_haddr_nxt      = r_naddr;
          w_htrans_nxt     = (w_first || r_naddr[9:0] == 10'd0) ? T_NSEQ : T_SEQ;
          w_wbuf_nxt       = bus.WD_DATA;
          w_naddr_nxt      = r_naddr + (ADDR_WIDTH'(1) << r_hsize);
          w_issue_left_nxt = r_issue_left - 9'd1;
        end else begin
          w_htrans_nxt = (r_issue_left != 9'd0 && !w_first) ? T_BUSY : T_IDLE;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_haddr      <= '0;
      r_htrans     <= T_IDLE;
      r_hwrite     <= 1'b0;
      r_hsize      <= '0;
      r_hburst     <= '0;
      r_hwdata     <= '0;
      r_wbuf       <= '0;
      r_naddr      <= '0;
      r_len        <= '0;
      r_issue_left <= '0;
      r_data_left  <= '0;
      r_dphase     <= 1'b0;
      r_to_cnt     <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_to_err     <= 1'b0;
    end else begin
      r_haddr      <= w_haddr_nxt;
      r_htrans     <= w_htrans_nxt;
      r_hwrite     <= w_hwrite_nxt;
      r_hsize      <= w_hsize_nxt;
      r_hburst     <= w_hburst_nxt;
      r_hwdata     <= w_hwdata_nxt;
      r_wbuf       <= w_wbuf_nxt;
      r_naddr      <= w_naddr_nxt;
      r_len        <= w_len_nxt;
      r_issue_left <= w_issue_left_nxt;
      r_data_left  <= w_data_left_nxt;
      r_dphase     <= w_dphase_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_rd_last    <= w_rd_last_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_to_err     <= w_to_err_nxt;
    end
  end

  assign bus.CMD_READY   = w_cmd_ready;
  assign bus.WD_READY    = w_issue & (w_accept ? bus.CMD_WRITE : r_hwrite);
  assign bus.RD_VALID    = r_rd_valid;
  assign bus.RD_LAST     = r_rd_last;
  assign bus.RD_DATA     = r_rd_data;
  assign bus.HADDR       = r_haddr;
  assign bus.HTRANS      = r_htrans;
  assign bus.HWRITE      = r_hwrite;
  assign bus.HSIZE       = r_hsize;
  assign bus.HBURST      = r_hburst;
  assign bus.HWDATA      = r_hwdata;
  assign bus.DONE        = r_done;
  assign bus.ERROR       = r_error;
  assign bus.TIMEOUT_ERR = r_to_err;
endmodule

// File: tb/tb_bfm_ahbl_master.sv
// Directed bench for bfm_ahbl_master: single write, 1 KB-crossing read, write with
// data gaps, error abort, timeout, rejected commands and reset mid-burst.
module tb_bfm_ahbl_master;
  localparam int TO = 16;

  logic SYSCLK = 1'b0;
  logic SYSRST;
  int   n_vec = 0;
  int   n_bad = 0;

  bfm_ahbl_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  bfm_ahbl_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16), .TIMEOUT(TO)) dut (
    .SYSCLK (SYSCLK),
    .SYSRST (SYSRST),
    .bus    (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [8:0] len);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = a;
    bus.CMD_SIZE  = sz;
    bus.CMD_LEN   = len;
  endtask

  initial begin
    SYSRST = 1'b1;
    bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_SIZE = '0;
    bus.CMD_LEN = '0; bus.WD_VALID = 1'b0; bus.WD_DATA = '0; bus.HRDATA = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;

    // reset state
    #12;
    chk("rst_cmd_ready", bus.CMD_READY, 0);
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_error", bus.ERROR, 0);
    chk("rst_rd_valid", bus.RD_VALID, 0);
    SYSRST = 1'b0;
    #1;
    chk("post_rst_cmd_ready", bus.CMD_READY, 1);

    // single write
    cmd(1'b1, 32'h100, 3'd2, 9'd1);
    bus.WD_VALID = 1'b1; bus.WD_DATA = 32'hCAFE0001;
    #1;
    chk("t1_wd_ready", bus.WD_READY, 1);
    tick(); bus.CMD_VALID = 1'b0; bus.WD_VALID = 1'b0;
    chk("t1_c1_htrans", bus.HTRANS, 2);
    chk("t1_c1_haddr", bus.HADDR, 32'h100);
    chk("t1_c1_hburst", bus.HBURST, 0);
    chk("t1_c1_hwrite", bus.HWRITE, 1);
    chk("t1_c1_hsize", bus.HSIZE, 2);
    chk("t1_c1_cmd_ready", bus.CMD_READY, 0);
    tick();
    chk("t1_c2_htrans", bus.HTRANS, 0);
    chk("t1_c2_hwdata", bus.HWDATA, 32'hCAFE0001);
    chk("t1_c2_done", bus.DONE, 0);
    tick();
    chk("t1_c3_done", bus.DONE, 1);
    chk("t1_c3_error", bus.ERROR, 0);
    tick();
    chk("t1_c4_done", bus.DONE, 0);
    chk("t1_c4_cmd_ready", bus.CMD_READY, 1);

    // read len 4 across the 1 KB boundary
    cmd(1'b0, 32'h3F8, 3'd2, 9'd4);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t2_c1_htrans", bus.HTRANS, 2);
    chk("t2_c1_haddr", bus.HADDR, 32'h3F8);
    chk("t2_c1_hburst", bus.HBURST, 1);
    tick();
    chk("t2_c2_htrans", bus.HTRANS, 3);
    chk("t2_c2_haddr", bus.HADDR, 32'h3FC);
    bus.HRDATA = 32'hA1;
    tick();
    chk("t2_c3_htrans", bus.HTRANS, 2);
    chk("t2_c3_haddr", bus.HADDR, 32'h400);
    chk("t2_c3_rd_valid", bus.RD_VALID, 1);
    chk("t2_c3_rd_data", bus.RD_DATA, 32'hA1);
    chk("t2_c3_rd_last", bus.RD_LAST, 0);
    bus.HRDATA = 32'hA2;
    tick();
    chk("t2_c4_htrans", bus.HTRANS, 3);
    chk("t2_c4_haddr", bus.HADDR, 32'h404);
    chk("t2_c4_rd_data", bus.RD_DATA, 32'hA2);
    bus.HRDATA = 32'hA3;
    tick();
    chk("t2_c5_htrans", bus.HTRANS, 0);
    chk("t2_c5_rd_data", bus.RD_DATA, 32'hA3);
    chk("t2_c5_done", bus.DONE, 0);
    bus.HRDATA = 32'hA4;
    tick();
    chk("t2_c6_rd_valid", bus.RD_VALID, 1);
    chk("t2_c6_rd_data", bus.RD_DATA, 32'hA4);
    chk("t2_c6_rd_last", bus.RD_LAST, 1);
    chk("t2_c6_done", bus.DONE, 1);
    tick();
    chk("t2_c7_rd_valid", bus.RD_VALID, 0);
    chk("t2_c7_done", bus.DONE, 0);

    // write len 4, write data missing for two cycles before beat 3
    cmd(1'b1, 32'h200, 3'd2, 9'd4);
    bus.WD_VALID = 1'b1; bus.WD_DATA = 32'h11110001;
    #1;
    chk("t3_c0_wd_ready", bus.WD_READY, 1);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t3_c1_htrans", bus.HTRANS, 2);
    chk("t3_c1_haddr", bus.HADDR, 32'h200);
    bus.WD_DATA = 32'h11110002;
    #1;
    chk("t3_c1_wd_ready", bus.WD_READY, 1);
    tick();
    chk("t3_c2_htrans", bus.HTRANS, 3);
    chk("t3_c2_haddr", bus.HADDR, 32'h204);
    chk("t3_c2_hwdata", bus.HWDATA, 32'h11110001);
    bus.WD_VALID = 1'b0;
    #1;
    chk("t3_c2_wd_ready", bus.WD_READY, 0);
    tick();
    chk("t3_c3_htrans_busy", bus.HTRANS, 1);
    chk("t3_c3_haddr", bus.HADDR, 32'h204);
    chk("t3_c3_hwdata", bus.HWDATA, 32'h11110002);
    chk("t3_c3_wd_ready", bus.WD_READY, 0);
    tick();
    chk("t3_c4_htrans_busy", bus.HTRANS, 1);
    chk("t3_c4_haddr", bus.HADDR, 32'h204);
    bus.WD_VALID = 1'b1; bus.WD_DATA = 32'h11110003;
    #1;
    chk("t3_c4_wd_ready", bus.WD_READY, 1);
    tick();
    chk("t3_c5_htrans", bus.HTRANS, 3);
    chk("t3_c5_haddr", bus.HADDR, 32'h208);
    bus.WD_DATA = 32'h11110004;
    #1;
    chk("t3_c5_wd_ready", bus.WD_READY, 1);
    tick(); bus.WD_VALID = 1'b0;
    chk("t3_c6_htrans", bus.HTRANS, 3);
    chk("t3_c6_haddr", bus.HADDR, 32'h20C);
    chk("t3_c6_hwdata", bus.HWDATA, 32'h11110003);
    tick();
    chk("t3_c7_htrans", bus.HTRANS, 0);
    chk("t3_c7_hwdata", bus.HWDATA, 32'h11110004);
    chk("t3_c7_done", bus.DONE, 0);
    tick();
    chk("t3_c8_done", bus.DONE, 1);

    // read len 8, error response on beat 3
    tick();
    cmd(1'b0, 32'h0, 3'd2, 9'd8);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t4_c1_htrans", bus.HTRANS, 2);
    tick();
    chk("t4_c2_haddr", bus.HADDR, 32'h4);
    bus.HRDATA = 32'hB1;
    tick();
    chk("t4_c3_rd_valid", bus.RD_VALID, 1);
    chk("t4_c3_rd_data", bus.RD_DATA, 32'hB1);
    bus.HRDATA = 32'hB2;
    tick();
    chk("t4_c4_htrans", bus.HTRANS, 3);
    chk("t4_c4_haddr", bus.HADDR, 32'hC);
    chk("t4_c4_rd_data", bus.RD_DATA, 32'hB2);
    bus.HREADY = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = 32'hBAD;
    tick();
    chk("t4_c5_htrans_idle", bus.HTRANS, 0);
    chk("t4_c5_rd_valid", bus.RD_VALID, 0);
    chk("t4_c5_error", bus.ERROR, 1);
    chk("t4_c5_done", bus.DONE, 0);
    bus.HREADY = 1'b1;
    tick(); bus.HRESP = 1'b0;
    chk("t4_c6_done", bus.DONE, 1);
    chk("t4_c6_rd_valid", bus.RD_VALID, 0);
    chk("t4_c6_htrans", bus.HTRANS, 0);
    tick();
    chk("t4_c7_done", bus.DONE, 0);
    chk("t4_c7_rd_valid", bus.RD_VALID, 0);
    chk("t4_c7_error_sticky", bus.ERROR, 1);
    chk("t4_c7_cmd_ready", bus.CMD_READY, 1);

    // HREADY held low for TO cycles in a data phase
    cmd(1'b0, 32'h40, 3'd2, 9'd1);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t5_c1_htrans", bus.HTRANS, 2);
    chk("t5_c1_error_cleared", bus.ERROR, 0);
    tick();
    bus.HREADY = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("t5_no_early_done", bus.DONE, 0);
    end
    tick();
    chk("t5_done", bus.DONE, 1);
    chk("t5_timeout_err", bus.TIMEOUT_ERR, 1);
    chk("t5_htrans", bus.HTRANS, 0);
    chk("t5_rd_valid", bus.RD_VALID, 0);
    bus.HREADY = 1'b1;
    tick();
    chk("t5_done_low", bus.DONE, 0);
    chk("t5_timeout_sticky", bus.TIMEOUT_ERR, 1);
    chk("t5_cmd_ready", bus.CMD_READY, 1);

    // size wider than the bus is rejected
    cmd(1'b1, 32'h80, 3'd3, 9'd1);
    bus.WD_VALID = 1'b1;
    #1;
    chk("t6_wd_ready", bus.WD_READY, 0);
    tick(); bus.CMD_VALID = 1'b0; bus.WD_VALID = 1'b0;
    chk("t6_htrans", bus.HTRANS, 0);
    chk("t6_error", bus.ERROR, 1);
    chk("t6_done", bus.DONE, 1);
    chk("t6_timeout_cleared", bus.TIMEOUT_ERR, 0);
    tick();
    chk("t6_done_low", bus.DONE, 0);
    chk("t6_htrans_c2", bus.HTRANS, 0);

    // length above MAX_BURST and zero length are rejected
    cmd(1'b0, 32'h80, 3'd2, 9'd17);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t6_len17_done", bus.DONE, 1);
    chk("t6_len17_error", bus.ERROR, 1);
    chk("t6_len17_htrans", bus.HTRANS, 0);
    tick();
    cmd(1'b0, 32'h80, 3'd2, 9'd0);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t6_len0_done", bus.DONE, 1);
    chk("t6_len0_htrans", bus.HTRANS, 0);
    tick();

    // reset mid-burst abandons the command
    cmd(1'b0, 32'h500, 3'd2, 9'd4);
    tick(); bus.CMD_VALID = 1'b0;
    chk("t7_c1_htrans", bus.HTRANS, 2);
    tick();
    #2 SYSRST = 1'b1;
    #1;
    chk("t7_rst_htrans", bus.HTRANS, 0);
    chk("t7_rst_haddr", bus.HADDR, 0);
    chk("t7_rst_cmd_ready", bus.CMD_READY, 0);
    SYSRST = 1'b0;
    #1;
    chk("t7_cmd_ready", bus.CMD_READY, 1);
    tick();
    chk("t7_no_done_a", bus.DONE, 0);
    tick();
    chk("t7_no_done_b", bus.DONE, 0);
    chk("t7_no_rd_valid", bus.RD_VALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
